// File: rtl/pipelined_prefix_adder.sv
// pipelined_prefix_adder: pipelined Kogge-Stone adder/subtractor with flags, tag and valid/ready.
//   Parameters: DATA_SIZE operand width (>=2), LEVELS_PER_STAGE prefix levels per register
//   stage, TAG_W sideband width. Latency is ceil(clog2(DATA_SIZE)/LEVELS_PER_STAGE)+1.
//   Ports: clk, rst_n (async, active low); in_valid/in_ready, a, b, cin, sub, in_tag accept a beat;
//   out_valid/out_ready, s, cout, ovf, zero, out_tag return it in acceptance order.
module pipelined_prefix_adder #(
    parameter int DATA_SIZE        = 32,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int TAG_W            = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  logic                 cin,
    input  logic                 sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] s,
    output logic                 cout,
    output logic                 ovf,
    output logic                 zero,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int N      = DATA_SIZE;
    localparam int LEVELS = $clog2(DATA_SIZE);
    localparam int NSTG   = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    // Stage r holds group generate g_q[r]; group propagate is only needed up to the
    // stage feeding the last one, so p_q stops at NSTG-1. pr_q carries the raw
    // bitwise propagate through to the sum XOR.
    logic [NSTG:0]                 v_q;
    logic [NSTG:0][N-1:0]          g_q;
    logic [NSTG-1:0][N-1:0]        p_q;
    logic [NSTG:0][N-1:0]          pr_q;
    logic [NSTG:0]                 c0_q;
    logic [NSTG:0][TAG_W-1:0]      tag_q;
    logic [NSTG:1][N-1:0]          g_d;
    logic [NSTG-1:0][N-1:0]        p_d;
    logic [N-1:0]                  bb;
    logic [N-1:0]                  g_in;
    logic [N-1:0]                  gc;
    logic                          c0;
    logic                          en;

    assign out_valid = v_q[NSTG];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign bb        = sub ? ~b : b;
    assign c0        = sub | cin;
    // Carry-in enters as an extra generate term on bit 0, so Gc[i] already includes it.
    assign g_in      = (a & bb) | {{(N-1){1'b0}}, (a[0] ^ bb[0]) & c0};

    always_comb begin : prefix
        logic [N-1:0] gt, pt;
        int k;
        g_d    = '0;
        p_d    = '0;
        p_d[0] = a ^ bb;
        gt     = '0;
        pt     = '0;
        k      = 0;
        for (int r = 1; r <= NSTG; r++) begin
            gt = g_q[r-1];
            pt = p_q[r-1];
            for (int l = 0; l < LEVELS_PER_STAGE; l++) begin
                k = (r - 1) * LEVELS_PER_STAGE + l;
                if (k < LEVELS) begin
                    // Shifting in zeros / ones makes bits below the span pass through.
                    gt = gt | (pt & (gt << (1 << k)));
                    pt = pt & ~((~pt) << (1 << k));
                end
            end
            g_d[r] = gt;
            if (r < NSTG) p_d[r] = pt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            g_q   <= '0;
            p_q   <= '0;
            pr_q  <= '0;
            c0_q  <= '0;
            tag_q <= '0;
        end else if (en) begin
            v_q <= {v_q[NSTG-1:0], in_valid};
            if (in_valid) begin
                g_q[0]   <= g_in;
                p_q[0]   <= p_d[0];
                pr_q[0]  <= a ^ bb;
                c0_q[0]  <= c0;
                tag_q[0] <= in_tag;
            end
            for (int r = 1; r <= NSTG; r++) begin
                if (v_q[r-1]) begin
                    g_q[r]   <= g_d[r];
                    pr_q[r]  <= pr_q[r-1];
                    c0_q[r]  <= c0_q[r-1];
                    tag_q[r] <= tag_q[r-1];
                    if (r < NSTG) p_q[r] <= p_d[r];
                end
            end
        end
    end

    assign gc      = g_q[NSTG];
    assign s       = pr_q[NSTG] ^ {gc[N-2:0], c0_q[NSTG]};
    assign cout    = gc[N-1];
    assign ovf     = gc[N-1] ^ gc[N-2];
    assign zero    = ~|s;
    assign out_tag = tag_q[NSTG];
endmodule
